// File: rtl/axis_uart.sv
`timescale 1ns/1ps
// axis_uart: full-duplex 8N1 UART with AXI-Stream byte ports and a run-time baud prescale.
// Define AXIS_UART_RX_SYNC_EN to pass rxd through a two-flop synchronizer (adds 2 cycles of RX latency).
module axis_uart #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    input  logic [15:0]           prescale,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error
);

    localparam int TW = 19;
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Timer reload values: a full bit is 8P cycles, the start-bit midpoint is 4P.
    logic [15:0]   p_eff;
    logic [TW-1:0] bit_len;
    logic [TW-1:0] half_len;

    assign p_eff    = (prescale == 16'd0) ? 16'd1 : prescale;
    assign bit_len  = {p_eff, 3'b000} - TW'(1);
    assign half_len = {1'b0, p_eff, 2'b00} - TW'(1);

    logic rx_in;

`ifdef AXIS_UART_RX_SYNC_EN
    logic [1:0] rx_sync;

    always_ff @(posedge clk) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], rxd};
    end

    assign rx_in = rx_sync[1];
`else
    assign rx_in = rxd;
`endif

    // ---------------- transmitter ----------------
    tx_state_t             tx_state, tx_state_d;
    logic [TW-1:0]         tx_timer, tx_timer_d;
    logic [TW-1:0]         tx_len, tx_len_d;
    logic [IW-1:0]         tx_idx, tx_idx_d;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_d;
    logic                  txd_d, tx_ready_d, tx_busy_d;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            tx_state          <= TX_IDLE;
            tx_timer          <= '0;
            tx_len            <= '0;
            tx_idx            <= '0;
            tx_shift          <= '0;
            txd               <= 1'b1;
            input_axis_tready <= 1'b0;
            tx_busy           <= 1'b0;
        end else begin
            tx_state          <= tx_state_d;
            tx_timer          <= tx_timer_d;
            tx_len            <= tx_len_d;
            tx_idx            <= tx_idx_d;
            tx_shift          <= tx_shift_d;
            txd               <= txd_d;
            input_axis_tready <= tx_ready_d;
            tx_busy           <= tx_busy_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a hold value first so no path through this block infers a latch.
        tx_state_d = tx_state;
        tx_timer_d = tx_timer;
        tx_len_d   = tx_len;
        tx_idx_d   = tx_idx;
        tx_shift_d = tx_shift;
        txd_d      = txd;
        tx_ready_d = input_axis_tready;
        tx_busy_d  = tx_busy;

        unique case (tx_state)
            TX_IDLE: begin
                tx_ready_d = 1'b1;
                if (input_axis_tvalid && input_axis_tready) begin
                    tx_shift_d = input_axis_tdata;
                    tx_len_d   = bit_len;
                    tx_ready_d = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                txd_d      = 1'b0;
                tx_timer_d = tx_len;
                tx_state_d = TX_START;
            end
            TX_START: begin
                if (tx_timer == '0) begin
                    txd_d      = tx_shift[0];
                    tx_shift_d = tx_shift >> 1;
                    tx_idx_d   = '0;
                    tx_timer_d = tx_len;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_timer_d = tx_timer - TW'(1);
                end
            end
            TX_DATA: begin
                if (tx_timer == '0) begin
                    tx_timer_d = tx_len;
                    if (tx_idx == LAST_IDX) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        txd_d      = tx_shift[0];
                        tx_shift_d = tx_shift >> 1;
                        tx_idx_d   = tx_idx + IW'(1);
                    end
                end else begin
                    tx_timer_d = tx_timer - TW'(1);
                end
            end
            TX_STOP: begin
                if (tx_timer == '0) begin
                    tx_ready_d = 1'b1;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_timer_d = tx_timer - TW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    rx_state_t             rx_state, rx_state_d;
    logic [TW-1:0]         rx_timer, rx_timer_d;
    logic [TW-1:0]         rx_len, rx_len_d;
    logic [IW-1:0]         rx_idx, rx_idx_d;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_d;
    logic                  rx_busy_d;
    logic                  rx_done, rx_done_d;
    logic                  rx_stop, rx_stop_d;
    logic [DATA_WIDTH-1:0] rx_tdata_d;
    logic                  rx_tvalid_d, rx_ovr_d, rx_ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state           <= RX_IDLE;
            rx_timer           <= '0;
            rx_len             <= '0;
            rx_idx             <= '0;
            rx_shift           <= '0;
            rx_busy            <= 1'b0;
            rx_done            <= 1'b0;
            rx_stop            <= 1'b0;
            output_axis_tdata  <= '0;
            output_axis_tvalid <= 1'b0;
            rx_overrun_error   <= 1'b0;
            rx_frame_error     <= 1'b0;
        end else begin
            rx_state           <= rx_state_d;
            rx_timer           <= rx_timer_d;
            rx_len             <= rx_len_d;
            rx_idx             <= rx_idx_d;
            rx_shift           <= rx_shift_d;
            rx_busy            <= rx_busy_d;
            rx_done            <= rx_done_d;
            rx_stop            <= rx_stop_d;
            output_axis_tdata  <= rx_tdata_d;
            output_axis_tvalid <= rx_tvalid_d;
            rx_overrun_error   <= rx_ovr_d;
            rx_frame_error     <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_timer_d = rx_timer;
        rx_len_d   = rx_len;
        rx_idx_d   = rx_idx;
        rx_shift_d = rx_shift;
        rx_busy_d  = rx_busy;
        rx_done_d  = 1'b0;
        rx_stop_d  = rx_stop;

        unique case (rx_state)
            RX_IDLE: begin
                if (!rx_in) begin
                    rx_len_d   = bit_len;
                    rx_timer_d = half_len;
                    rx_busy_d  = 1'b1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_timer == '0) begin
                    if (rx_in) begin
                        rx_busy_d  = 1'b0;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_idx_d   = '0;
                        rx_timer_d = rx_len;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_timer_d = rx_timer - TW'(1);
                end
            end
            RX_DATA: begin
                if (rx_timer == '0) begin
                    rx_shift_d = {rx_in, rx_shift[DATA_WIDTH-1:1]};
                    rx_timer_d = rx_len;
                    if (rx_idx == LAST_IDX) rx_state_d = RX_STOP;
                    else                    rx_idx_d   = rx_idx + IW'(1);
                end else begin
                    rx_timer_d = rx_timer - TW'(1);
                end
            end
            RX_STOP: begin
                if (rx_timer == '0) begin
                    rx_done_d  = 1'b1;
                    rx_stop_d  = rx_in;
                    rx_busy_d  = 1'b0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_timer_d = rx_timer - TW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // Output stage runs one cycle behind the stop-bit sample; a new byte beats a same-cycle consume.
        rx_tdata_d  = output_axis_tdata;
        rx_tvalid_d = output_axis_tvalid && !output_axis_tready;
        rx_ovr_d    = 1'b0;
        rx_ferr_d   = 1'b0;
        if (rx_done) begin
            if (rx_stop) begin
                rx_tdata_d  = rx_shift;
                rx_tvalid_d = 1'b1;
                rx_ovr_d    = output_axis_tvalid && !output_axis_tready;
            end else begin
                rx_ferr_d   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart.sv
`timescale 1ns/1ps
// Self-checking bench for axis_uart: TX waveform table, loopback against a byte-queue model,
// and directed RX framing, overrun, false-start and mid-frame reset sequences.
module tb_axis_uart;

`ifdef AXIS_UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_tdata = 8'h00;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rxd_w;
    logic        txd;
    logic [15:0] prescale = 16'd1;
    logic        tx_busy, rx_busy, ovr, ferr;

    assign rxd_w = loop_en ? txd : rxd_drv;

    axis_uart #(.DATA_WIDTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_axis_tdata   (in_tdata),
        .input_axis_tvalid  (in_tvalid),
        .input_axis_tready  (in_tready),
        .output_axis_tdata  (out_tdata),
        .output_axis_tvalid (out_tvalid),
        .output_axis_tready (out_tready),
        .rxd                (rxd_w),
        .txd                (txd),
        .prescale           (prescale),
        .tx_busy            (tx_busy),
        .rx_busy            (rx_busy),
        .rx_overrun_error   (ovr),
        .rx_frame_error     (ferr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Consumer and monitor: rdy_mode 0 = stall, 1 = always ready, 2 = random ready.
    int         rdy_mode = 1;
    logic [7:0] rx_q[$];
    int         ovr_cnt = 0;
    int         ferr_cnt = 0;

    always @(negedge clk) begin
        if (rdy_mode == 2) out_tready = 1'($urandom_range(0, 1));
        else               out_tready = (rdy_mode == 1);
        if (!rst) begin
            if (out_tvalid && out_tready) rx_q.push_back(out_tdata);
            if (ovr)  ovr_cnt++;
            if (ferr) ferr_cnt++;
        end
    end

    task automatic tx_send(input logic [7:0] d);
        int n = 0;
        in_tdata  = d;
        in_tvalid = 1'b1;
        while (!in_tready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("tx_send_timeout", 32'(n), 32'(LIMIT - 1));
        @(negedge clk);
        in_tvalid = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        int n = 0;
        while (rx_q.size() < target && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("wait_rx_timeout", 32'(rx_q.size()), 32'(target));
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (!in_tready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("wait_tx_idle_timeout", 32'(in_tready), 32'd1);
    endtask

    // Drives one serial frame on rxd; rise = negedge index where tvalid was first seen high, -1 if never.
    task automatic rx_frame(input logic [7:0] d, input logic stop, input int p, output int rise);
        logic [9:0] f;
        int j = 0;
        f    = {stop, d, 1'b0};
        rise = -1;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 8 * p; c++) begin
                rxd_drv = f[b];
                @(negedge clk);
                j++;
                if (rise < 0 && out_tvalid) rise = j;
            end
        end
        rxd_drv = 1'b1;
        for (int c = 0; c < 8 * p + 4; c++) begin
            @(negedge clk);
            j++;
            if (rise < 0 && out_tvalid) rise = j;
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [15:0] p;
        logic [15:0] p_mid;
        logic [9:0]  line;
        int          bit_cycles;
    } tx_vec_t;

    tx_vec_t    tx_vecs[4];
    logic [7:0] exp_q[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        int base, ovr0, ferr0, rd, bad, busy_cycles, nb;
        logic [7:0] d;

        tx_vecs[0] = '{8'hA5, 16'd1, 16'd3, 10'b1101001010, 8};
        tx_vecs[1] = '{8'h00, 16'd0, 16'd2, 10'b1000000000, 8};
        tx_vecs[2] = '{8'hFF, 16'd2, 16'd1, 10'b1111111110, 16};
        tx_vecs[3] = '{8'h3C, 16'd3, 16'd0, 10'b1001111000, 24};

        // Reset held for 3 edges
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tready", 32'(in_tready), 32'd0);
        check("rst_tvalid", 32'(out_tvalid), 32'd0);
        check("rst_tdata", 32'(out_tdata), 32'd0);
        check("rst_busy", {30'd0, tx_busy, rx_busy}, 32'd0);
        check("rst_errors", {30'd0, ovr, ferr}, 32'd0);
        @(negedge clk);
        check("rst_tready_after_release", 32'(in_tready), 32'd1);

        // TX waveform table; prescale is changed mid-frame and must not affect the current frame
        for (int i = 0; i < 4; i++) begin
            wait_tx_idle();
            prescale  = tx_vecs[i].p;
            in_tdata  = tx_vecs[i].data;
            in_tvalid = 1'b1;
            @(negedge clk);
            in_tvalid = 1'b0;
            prescale  = tx_vecs[i].p_mid;
            check($sformatf("tx_ready_drop_%02h", tx_vecs[i].data), 32'(in_tready), 32'd0);
            check($sformatf("tx_busy_set_%02h", tx_vecs[i].data), 32'(tx_busy), 32'd1);
            check($sformatf("tx_txd_before_start_%02h", tx_vecs[i].data), 32'(txd), 32'd1);
            for (int b = 0; b < 10; b++) begin
                bad = 0;
                for (int c = 0; c < tx_vecs[i].bit_cycles; c++) begin
                    @(negedge clk);
                    if (txd !== tx_vecs[i].line[b]) bad++;
                end
                check($sformatf("tx_%02h_bit%0d_wrong_cycles", tx_vecs[i].data, b), 32'(bad), 32'd0);
            end
            check($sformatf("tx_ready_early_%02h", tx_vecs[i].data), 32'(in_tready), 32'd0);
            @(negedge clk);
            check($sformatf("tx_ready_back_%02h", tx_vecs[i].data), 32'(in_tready), 32'd1);
            check($sformatf("tx_busy_clear_%02h", tx_vecs[i].data), 32'(tx_busy), 32'd0);
        end

        // Loopback, back-to-back 0x55 then 0x00 with the consumer always ready
        loop_en  = 1'b1;
        prescale = 16'd2;
        rdy_mode = 1;
        base  = rx_q.size();
        ovr0  = ovr_cnt;
        ferr0 = ferr_cnt;
        tx_send(8'h55);
        tx_send(8'h00);
        wait_rx(base + 2);
        if (rx_q.size() >= base + 2) begin
            check("loop_b2b_byte0", 32'(rx_q[base]), 32'h55);
            check("loop_b2b_byte1", 32'(rx_q[base + 1]), 32'h00);
        end
        check("loop_b2b_errors", 32'(ovr_cnt - ovr0 + ferr_cnt - ferr0), 32'd0);

        // Randomized loopback bursts against a byte-queue model, random consumer stalls
        rdy_mode = 2;
        rd = rx_q.size();
        for (int burst = 0; burst < 3; burst++) begin
            wait_tx_idle();
            prescale = 16'($urandom_range(0, 3));
            nb = $urandom_range(3, 5);
            for (int k = 0; k < nb; k++) begin
                d = 8'($urandom);
                exp_q.push_back(d);
                tx_send(d);
            end
            wait_rx(rd + exp_q.size());
            while (exp_q.size() > 0 && rx_q.size() > rd) begin
                check($sformatf("loop_rand_b%0d", burst), 32'(rx_q[rd]), 32'(exp_q.pop_front()));
                rd++;
            end
            exp_q.delete();
        end
        check("loop_rand_errors", 32'(ovr_cnt - ovr0 + ferr_cnt - ferr0), 32'd0);
        wait_tx_idle();
        repeat (40) @(negedge clk);
        loop_en  = 1'b0;
        rdy_mode = 1;
        @(negedge clk);

        // RX latency from first low sample to tvalid
        prescale = 16'd2;
        base = rx_q.size();
        rx_frame(8'h5A, 1'b1, 2, rise);
        check("rx_latency", 32'(rise), 32'(76 * 2 + 2 + SYNC_LAT));
        check("rx_count_5a", 32'(rx_q.size()), 32'(base + 1));
        if (rx_q.size() > base) check("rx_byte_5a", 32'(rx_q[base]), 32'h5A);

        // Framing error: stop bit low
        base  = rx_q.size();
        ovr0  = ovr_cnt;
        ferr0 = ferr_cnt;
        rx_frame(8'h3C, 1'b0, 2, rise);
        check("ferr_pulses", 32'(ferr_cnt - ferr0), 32'd1);
        check("ferr_no_valid", 32'(rise), 32'hFFFF_FFFF);
        check("ferr_no_byte", 32'(rx_q.size()), 32'(base));
        check("ferr_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
        check("ferr_rx_idle", 32'(rx_busy), 32'd0);

        // Overrun with the consumer stalled
        rdy_mode = 0;
        @(negedge clk);
        ovr0 = ovr_cnt;
        rx_frame(8'h11, 1'b1, 2, rise);
        check("ovr_first_no_pulse", 32'(ovr_cnt - ovr0), 32'd0);
        check("ovr_first_valid", 32'(out_tvalid), 32'd1);
        check("ovr_first_data", 32'(out_tdata), 32'h11);
        rx_frame(8'h22, 1'b1, 2, rise);
        check("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        check("ovr_valid_held", 32'(out_tvalid), 32'd1);
        check("ovr_data", 32'(out_tdata), 32'h22);
        base = rx_q.size();
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        check("ovr_drained_valid", 32'(out_tvalid), 32'd0);
        check("ovr_drained_count", 32'(rx_q.size()), 32'(base + 1));
        if (rx_q.size() > base) check("ovr_drained_byte", 32'(rx_q[base]), 32'h22);

        // False start: 1-cycle low glitch, P=4
        prescale = 16'd4;
        base  = rx_q.size();
        ovr0  = ovr_cnt;
        ferr0 = ferr_cnt;
        rxd_drv = 1'b0;
        @(negedge clk);
        rxd_drv = 1'b1;
        busy_cycles = 0;
        for (int n = 0; n < 60; n++) begin
            if (rx_busy) busy_cycles++;
            @(negedge clk);
        end
        check("false_start_busy_cycles", 32'(busy_cycles), 32'd16);
        check("false_start_rx_busy", 32'(rx_busy), 32'd0);
        check("false_start_no_byte", 32'(rx_q.size()), 32'(base));
        check("false_start_no_errors", 32'(ovr_cnt - ovr0 + ferr_cnt - ferr0), 32'd0);

        // Reset in the middle of a TX frame and an RX frame
        prescale = 16'd1;
        wait_tx_idle();
        in_tdata  = 8'hC3;
        in_tvalid = 1'b1;
        rxd_drv   = 1'b0;
        @(negedge clk);
        in_tvalid = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_tready", 32'(in_tready), 32'd0);
        check("midrst_busy", {30'd0, tx_busy, rx_busy}, 32'd0);
        check("midrst_tvalid", 32'(out_tvalid), 32'd0);
        check("midrst_tdata", 32'(out_tdata), 32'd0);
        rst     = 1'b0;
        rxd_drv = 1'b1;
        base  = rx_q.size();
        ovr0  = ovr_cnt;
        ferr0 = ferr_cnt;
        @(negedge clk);
        check("midrst_tready_back", 32'(in_tready), 32'd1);
        repeat (120) @(negedge clk);
        check("midrst_no_byte", 32'(rx_q.size()), 32'(base));
        check("midrst_no_errors", 32'(ovr_cnt - ovr0 + ferr_cnt - ferr0), 32'd0);
        check("midrst_txd_idle", 32'(txd), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
